// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU codes, control bundle, instruction classifier.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package decode_pkg;

   localparam int IDX_W = 5;
   localparam logic [IDX_W-1:0] XZR = 5'd31;

   // Major opcode fields, compared against the top bits of the instruction
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [5:0]  OP_B    = 6'b000101;

   // ALU operation codes seen by EX
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   typedef enum logic [3:0] {
      INS_ILLEGAL,
      INS_ADD,
      INS_SUB,
      INS_AND,
      INS_ORR,
      INS_ADDI,
      INS_LDUR,
      INS_STUR,
      INS_CBZ,
      INS_B
   } insClass_e;

   typedef struct packed {
      logic [3:0] aluCtl;
      logic       aluSrc;
      logic       memRead;
      logic       memWrite;
      logic       memToReg;
      logic       regWrite;
      logic       cbz;
      logic       uncond;
      logic       illegal;
   } ctrl_t;

   // A bubble carries no side effects and is not flagged illegal
   localparam ctrl_t CTRL_BUBBLE = '0;

   // Opcode groups are disjoint, so the order of tests does not matter
   function automatic insClass_e classify(input logic [31:0] instr);
      insClass_e c;
      c = INS_ILLEGAL;
      if (instr[31:21] == OP_ADD)       c = INS_ADD;
      else if (instr[31:21] == OP_SUB)  c = INS_SUB;
      else if (instr[31:21] == OP_AND)  c = INS_AND;
      else if (instr[31:21] == OP_ORR)  c = INS_ORR;
      else if (instr[31:21] == OP_LDUR) c = INS_LDUR;
      else if (instr[31:21] == OP_STUR) c = INS_STUR;
      else if (instr[31:22] == OP_ADDI) c = INS_ADDI;
      else if (instr[31:24] == OP_CBZ)  c = INS_CBZ;
      else if (instr[31:26] == OP_B)    c = INS_B;
      return c;
   endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry architectural register file, two combinational read ports, one write port; X31 reads as zero.
// Latency: reads 0 cycles (write-through bypass from the write port), writes land on the rising edge.
// Backpressure: none; a write is always accepted.
module register_file
   import decode_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              resetl,
   input  logic [IDX_W-1:0]  rdIdxA,
   input  logic [IDX_W-1:0]  rdIdxB,
   output logic [DATA_W-1:0] rdDataA,
   output logic [DATA_W-1:0] rdDataB,
   input  logic              wrEn,
   input  logic [IDX_W-1:0]  wrIdx,
   input  logic [DATA_W-1:0] wrData
);

   logic [DATA_W-1:0] regs [NREG];

   // Storage: clear on reset, never store into XZR
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wrEn && (wrIdx != XZR)) begin
         regs[wrIdx] <= wrData;
      end
   end

   // Port A: XZR first, then same-cycle write-back, then stored value
   always_comb begin
      rdDataA = regs[rdIdxA];
      if (rdIdxA == XZR)                    rdDataA = '0;
      else if (wrEn && (wrIdx == rdIdxA))   rdDataA = wrData;
   end

   // Port B: same priority as port A
   always_comb begin
      rdDataB = regs[rdIdxB];
      if (rdIdxB == XZR)                    rdDataB = '0;
      else if (wrEn && (wrIdx == rdIdxB))   rdDataB = wrData;
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: LEGv8 subset decode, operand read, immediate extension, load-use detect, ID/EX register.
// Latency: 1 cycle from instruction_ID to the *_EX outputs.
// Backpressure: a load-use hazard raises stall_IF for one cycle and inserts a bubble; flush overrides the stall.
module decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              resetl,
   input  logic [31:0]       instruction_ID,
   input  logic [DATA_W-1:0] pc_ID,
   input  logic              flush,
   input  logic              wb_regwrite,
   input  logic [IDX_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall_IF,
   output logic [DATA_W-1:0] pc_EX,
   output logic [DATA_W-1:0] busA_EX,
   output logic [DATA_W-1:0] busB_EX,
   output logic [DATA_W-1:0] imm_EX,
   output logic [IDX_W-1:0]  rd_EX,
   output logic [IDX_W-1:0]  rn_EX,
   output logic [IDX_W-1:0]  rm_EX,
   output logic [3:0]        aluctl_EX,
   output logic              alusrc_EX,
   output logic              memread_EX,
   output logic              memwrite_EX,
   output logic              memtoreg_EX,
   output logic              regwrite_EX,
   output logic              cbz_EX,
   output logic              uncond_EX,
   output logic              illegal_EX
);

   insClass_e         insClass;
   ctrl_t             decCtrl;
   logic [DATA_W-1:0] decImm;
   logic              useRn;
   logic              useSecond;
   logic              secondIsRt;
   logic [IDX_W-1:0]  rdIdx;
   logic [IDX_W-1:0]  rnIdx;
   logic [IDX_W-1:0]  rmIdx;
   logic [DATA_W-1:0] busA;
   logic [DATA_W-1:0] busB;
   logic              hazard;

   // ID/EX pipeline register contents
   ctrl_t             exCtrl;
   logic [DATA_W-1:0] exPc;
   logic [DATA_W-1:0] exBusA;
   logic [DATA_W-1:0] exBusB;
   logic [DATA_W-1:0] exImm;
   logic [IDX_W-1:0]  exRd;
   logic [IDX_W-1:0]  exRn;
   logic [IDX_W-1:0]  exRm;

   assign insClass = classify(instruction_ID);
   assign rdIdx    = instruction_ID[4:0];
   assign rnIdx    = instruction_ID[9:5];
   // Stores and CBZ read their data/test register from the Rt slot
   assign rmIdx    = secondIsRt ? instruction_ID[4:0] : instruction_ID[20:16];

   // Per-class controls, immediate form and which source fields are live
   always_comb begin
      decCtrl    = CTRL_BUBBLE;
      decImm     = '0;
      useRn      = 1'b0;
      useSecond  = 1'b0;
      secondIsRt = 1'b0;
      case (insClass)
         INS_ADD, INS_SUB, INS_AND, INS_ORR: begin
            decCtrl.regWrite = 1'b1;
            useRn            = 1'b1;
            useSecond        = 1'b1;
            case (insClass)
               INS_SUB: decCtrl.aluCtl = ALU_SUB;
               INS_AND: decCtrl.aluCtl = ALU_AND;
               INS_ORR: decCtrl.aluCtl = ALU_ORR;
               default: decCtrl.aluCtl = ALU_ADD;
            endcase
         end
         INS_ADDI: begin
            decCtrl.aluCtl   = ALU_ADD;
            decCtrl.aluSrc   = 1'b1;
            decCtrl.regWrite = 1'b1;
            decImm           = {{(DATA_W-12){1'b0}}, instruction_ID[21:10]};
            useRn            = 1'b1;
         end
         INS_LDUR: begin
            decCtrl.aluCtl   = ALU_ADD;
            decCtrl.aluSrc   = 1'b1;
            decCtrl.memRead  = 1'b1;
            decCtrl.memToReg = 1'b1;
            decCtrl.regWrite = 1'b1;
            decImm           = {{(DATA_W-9){instruction_ID[20]}}, instruction_ID[20:12]};
            useRn            = 1'b1;
         end
         INS_STUR: begin
            decCtrl.aluCtl   = ALU_ADD;
            decCtrl.aluSrc   = 1'b1;
            decCtrl.memWrite = 1'b1;
            decImm           = {{(DATA_W-9){instruction_ID[20]}}, instruction_ID[20:12]};
            useRn            = 1'b1;
            useSecond        = 1'b1;
            secondIsRt       = 1'b1;
         end
         INS_CBZ: begin
            decCtrl.aluCtl   = ALU_PASSB;
            decCtrl.cbz      = 1'b1;
            decImm           = {{(DATA_W-21){instruction_ID[23]}}, instruction_ID[23:5], 2'b00};
            useSecond        = 1'b1;
            secondIsRt       = 1'b1;
         end
         INS_B: begin
            decCtrl.uncond   = 1'b1;
            decImm           = {{(DATA_W-28){instruction_ID[25]}}, instruction_ID[25:0], 2'b00};
         end
         default: begin
            decCtrl.illegal  = 1'b1;
         end
      endcase
   end

   register_file #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk     (clk),
      .resetl  (resetl),
      .rdIdxA  (rnIdx),
      .rdIdxB  (rmIdx),
      .rdDataA (busA),
      .rdDataB (busB),
      .wrEn    (wb_regwrite),
      .wrIdx   (wb_rd),
      .wrData  (wb_data)
   );

   // Load in EX whose destination is a live source here; XZR never carries a dependency
   assign hazard = exCtrl.memRead && (exRd != XZR) &&
                   ((useRn && (exRd == rnIdx)) || (useSecond && (exRd == rmIdx)));

   // A flush redirects IF, so holding it would lose the branch target
   assign stall_IF = hazard & ~flush;

   // ID/EX register: flush or hazard injects an all-zero bubble
   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         exCtrl <= CTRL_BUBBLE;
         exPc   <= '0;
         exBusA <= '0;
         exBusB <= '0;
         exImm  <= '0;
         exRd   <= '0;
         exRn   <= '0;
         exRm   <= '0;
      end else if (flush || hazard) begin
         exCtrl <= CTRL_BUBBLE;
         exPc   <= '0;
         exBusA <= '0;
         exBusB <= '0;
         exImm  <= '0;
         exRd   <= '0;
         exRn   <= '0;
         exRm   <= '0;
      end else begin
         exCtrl <= decCtrl;
         exPc   <= pc_ID;
         exBusA <= busA;
         exBusB <= busB;
         exImm  <= decImm;
         exRd   <= rdIdx;
         exRn   <= rnIdx;
         exRm   <= rmIdx;
      end
   end

   assign pc_EX       = exPc;
   assign busA_EX     = exBusA;
   assign busB_EX     = exBusB;
   assign imm_EX      = exImm;
   assign rd_EX       = exRd;
   assign rn_EX       = exRn;
   assign rm_EX       = exRm;
   assign aluctl_EX   = exCtrl.aluCtl;
   assign alusrc_EX   = exCtrl.aluSrc;
   assign memread_EX  = exCtrl.memRead;
   assign memwrite_EX = exCtrl.memWrite;
   assign memtoreg_EX = exCtrl.memToReg;
   assign regwrite_EX = exCtrl.regWrite;
   assign cbz_EX      = exCtrl.cbz;
   assign uncond_EX   = exCtrl.uncond;
   assign illegal_EX  = exCtrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: behavioural opcode-table model, per-cycle compare, directed and random stimulus.
// Latency: model predicts the ID/EX contents one edge after each presented instruction.
// Backpressure: instruction and PC are held whenever the model says IF was stalled.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        resetl = 1'b1;
   logic [31:0] instruction_ID;
   logic [63:0] pc_ID;
   logic        flush;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        stall_IF;
   logic [63:0] pc_EX, busA_EX, busB_EX, imm_EX;
   logic [4:0]  rd_EX, rn_EX, rm_EX;
   logic [3:0]  aluctl_EX;
   logic        alusrc_EX, memread_EX, memwrite_EX, memtoreg_EX;
   logic        regwrite_EX, cbz_EX, uncond_EX, illegal_EX;

   int nTests;
   int nFail;

   decode_stage dut (
      .clk            (clk),
      .resetl         (resetl),
      .instruction_ID (instruction_ID),
      .pc_ID          (pc_ID),
      .flush          (flush),
      .wb_regwrite    (wb_regwrite),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .stall_IF       (stall_IF),
      .pc_EX          (pc_EX),
      .busA_EX        (busA_EX),
      .busB_EX        (busB_EX),
      .imm_EX         (imm_EX),
      .rd_EX          (rd_EX),
      .rn_EX          (rn_EX),
      .rm_EX          (rm_EX),
      .aluctl_EX      (aluctl_EX),
      .alusrc_EX      (alusrc_EX),
      .memread_EX     (memread_EX),
      .memwrite_EX    (memwrite_EX),
      .memtoreg_EX    (memtoreg_EX),
      .regwrite_EX    (regwrite_EX),
      .cbz_EX         (cbz_EX),
      .uncond_EX      (uncond_EX),
      .illegal_EX     (illegal_EX)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [63:0] pc, a, b, imm;
      logic [4:0]  rd, rn, rm;
      logic [3:0]  alu;
      logic        alusrc, memread, memwrite, memtoreg, regwrite, cbz, uncond, illegal;
   } ex_t;

   // flg order: alusrc memread memwrite memtoreg regwrite cbz uncond
   // immKind: 0 none, 1 zext imm12, 2 sext imm9, 3 sext imm19*4, 4 sext imm26*4
   typedef struct {
      logic [31:0] mask;
      logic [31:0] match;
      logic [3:0]  alu;
      logic [6:0]  flg;
      int          immKind;
      bit          usesRn;
      bit          usesSec;
      bit          secIsRt;
   } entry_t;

   entry_t      tbl [9];
   logic [63:0] mregs [32];
   ex_t         mExp;
   logic        lastStall;

   initial begin
      tbl[0] = '{32'hFFE00000, 32'h8B000000, 4'd2, 7'b0000100, 0, 1'b1, 1'b1, 1'b0}; // ADD
      tbl[1] = '{32'hFFE00000, 32'hCB000000, 4'd6, 7'b0000100, 0, 1'b1, 1'b1, 1'b0}; // SUB
      tbl[2] = '{32'hFFE00000, 32'h8A000000, 4'd0, 7'b0000100, 0, 1'b1, 1'b1, 1'b0}; // AND
      tbl[3] = '{32'hFFE00000, 32'hAA000000, 4'd1, 7'b0000100, 0, 1'b1, 1'b1, 1'b0}; // ORR
      tbl[4] = '{32'hFFC00000, 32'h91000000, 4'd2, 7'b1000100, 1, 1'b1, 1'b0, 1'b0}; // ADDI
      tbl[5] = '{32'hFFE00000, 32'hF8400000, 4'd2, 7'b1101100, 2, 1'b1, 1'b0, 1'b0}; // LDUR
      tbl[6] = '{32'hFFE00000, 32'hF8000000, 4'd2, 7'b1010000, 2, 1'b1, 1'b1, 1'b1}; // STUR
      tbl[7] = '{32'hFF000000, 32'hB4000000, 4'd7, 7'b0000010, 3, 1'b0, 1'b1, 1'b1}; // CBZ
      tbl[8] = '{32'hFC000000, 32'h14000000, 4'd0, 7'b0000001, 4, 1'b0, 1'b0, 1'b0}; // B
   end

   function automatic int findEntry(input logic [31:0] ins);
      for (int k = 0; k < 9; k++)
         if ((ins & tbl[k].mask) == tbl[k].match) return k;
      return -1;
   endfunction

   function automatic logic [4:0] secondIdx(input logic [31:0] ins);
      int k = findEntry(ins);
      return (k >= 0 && tbl[k].secIsRt) ? ins[4:0] : ins[20:16];
   endfunction

   function automatic logic [63:0] mread(input logic [4:0] idx);
      if (idx == 5'd31) return 64'd0;
      if (wb_regwrite && wb_rd == idx) return wb_data;
      return mregs[idx];
   endfunction

   function automatic logic modelHazard(input logic [31:0] ins);
      int k = findEntry(ins);
      if (k < 0 || !mExp.memread || mExp.rd == 5'd31) return 1'b0;
      return (tbl[k].usesRn && mExp.rd == ins[9:5]) ||
             (tbl[k].usesSec && mExp.rd == secondIdx(ins));
   endfunction

   function automatic ex_t modelDecode(input logic [31:0] ins, input logic [63:0] pc);
      ex_t    e;
      int     k;
      longint v;
      e    = '0;
      k    = findEntry(ins);
      e.pc = pc;
      e.rd = ins[4:0];
      e.rn = ins[9:5];
      e.rm = secondIdx(ins);
      e.a  = mread(e.rn);
      e.b  = mread(e.rm);
      if (k < 0) begin
         e.illegal = 1'b1;
      end else begin
         e.alu = tbl[k].alu;
         {e.alusrc, e.memread, e.memwrite, e.memtoreg, e.regwrite, e.cbz, e.uncond} = tbl[k].flg;
         case (tbl[k].immKind)
            1: e.imm = 64'(ins[21:10]);
            2: begin v = longint'(ins[20:12]); if (v >= 256) v -= 512; e.imm = v; end
            3: begin v = longint'(ins[23:5]); if (v >= (1 << 18)) v -= (1 << 19); e.imm = v * 4; end
            4: begin v = longint'(ins[25:0]); if (v >= (1 << 25)) v -= (1 << 26); e.imm = v * 4; end
            default: e.imm = 64'd0;
         endcase
      end
      return e;
   endfunction

   // Model state advances on the same edges as the pipeline register
   always @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         mExp      = '0;
         lastStall = 1'b0;
         for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
      end else begin
         logic hz;
         ex_t  d;
         hz        = modelHazard(instruction_ID);
         d         = modelDecode(instruction_ID, pc_ID);
         lastStall = hz && !flush;
         mExp      = (flush || hz) ? ex_t'(0) : d;
         if (wb_regwrite && wb_rd != 5'd31) mregs[wb_rd] = wb_data;
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
      nTests++;
      if (act !== want) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
      end
   endtask

   // Per-cycle compare, away from the active edge
   always @(negedge clk) begin
      check("pc_EX", pc_EX, mExp.pc);
      check("busA_EX", busA_EX, mExp.a);
      check("busB_EX", busB_EX, mExp.b);
      check("imm_EX", imm_EX, mExp.imm);
      check("rd_EX", 64'(rd_EX), 64'(mExp.rd));
      check("rn_EX", 64'(rn_EX), 64'(mExp.rn));
      check("rm_EX", 64'(rm_EX), 64'(mExp.rm));
      check("aluctl_EX", 64'(aluctl_EX), 64'(mExp.alu));
      check("ctl_EX", 64'({alusrc_EX, memread_EX, memwrite_EX, memtoreg_EX, regwrite_EX,
                           cbz_EX, uncond_EX, illegal_EX}),
            64'({mExp.alusrc, mExp.memread, mExp.memwrite, mExp.memtoreg, mExp.regwrite,
                 mExp.cbz, mExp.uncond, mExp.illegal}));
      check("stall_IF", 64'(stall_IF), 64'(modelHazard(instruction_ID) && !flush));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic fl,
                        input logic we, input logic [4:0] wr, input logic [63:0] wd);
      instruction_ID = ins;
      pc_ID          = pc;
      flush          = fl;
      wb_regwrite    = we;
      wb_rd          = wr;
      wb_data        = wd;
   endtask

   function automatic logic [4:0] ridx();
      int r = $urandom_range(0, 8);
      return (r == 8) ? 5'd31 : 5'(r);
   endfunction

   function automatic logic [31:0] genInstr();
      logic [31:0] r;
      logic [4:0]  a, b, c;
      r = $urandom;
      a = ridx();
      b = ridx();
      c = ridx();
      case ($urandom_range(0, 9))
         0: return {11'b10001011000, c, r[5:0], b, a};
         1: return {11'b11001011000, c, r[5:0], b, a};
         2: return {11'b10001010000, c, r[5:0], b, a};
         3: return {11'b10101010000, c, r[5:0], b, a};
         4: return {10'b1001000100, r[11:0], b, a};
         5: return {11'b11111000010, r[8:0], 2'b00, b, a};
         6: return {11'b11111000000, r[8:0], 2'b00, b, a};
         7: return {8'b10110100, r[18:0], a};
         8: return {6'b000101, r[25:0]};
         default: return r;
      endcase
   endfunction

   localparam logic [31:0] I_ADD   = 32'h8B020023; // ADD X3,X1,X2
   localparam logic [31:0] I_ADDZ  = 32'h8B0203E3; // ADD X3,XZR,X2
   localparam logic [31:0] I_LDUR  = 32'hF8408022; // LDUR X2,[X1,#8]
   localparam logic [31:0] I_DEP   = 32'h8B040043; // ADD X3,X2,X4
   localparam logic [31:0] I_CBZ   = 32'hB4FFFF85; // CBZ X5,-4
   localparam logic [31:0] I_ILL   = 32'h0B000004;

   logic [31:0] curIns;
   logic [63:0] curPc;

   initial begin
      nTests = 0;
      nFail  = 0;
      drive(32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);

      // Asynchronous reset before any clock edge
      #1 resetl = 1'b0;
      #2;
      check("rst pc_EX", pc_EX, 64'd0);
      check("rst memread_EX", 64'(memread_EX), 64'd0);
      check("rst illegal_EX", 64'(illegal_EX), 64'd0);
      check("rst stall_IF", 64'(stall_IF), 64'd0);
      tick();
      tick();
      resetl = 1'b1;

      // R-type with values written through WB
      drive(32'd0, 64'h100, 1'b0, 1'b1, 5'd1, 64'h1234); tick();
      drive(32'd0, 64'h104, 1'b0, 1'b1, 5'd2, 64'd5);    tick();
      drive(I_ADD, 64'h200, 1'b0, 1'b0, 5'd0, 64'd0);    tick();
      check("add busA", busA_EX, 64'h1234);
      check("add busB", busB_EX, 64'd5);
      check("add rd", 64'(rd_EX), 64'd3);
      check("add aluctl", 64'(aluctl_EX), 64'b0010);
      check("add regwrite", 64'(regwrite_EX), 64'd1);
      check("add alusrc", 64'(alusrc_EX), 64'd0);

      // Write-through bypass, then XZR stays zero
      drive(I_ADD, 64'h204, 1'b0, 1'b1, 5'd1, 64'hAA);   tick();
      check("bypass busA", busA_EX, 64'hAA);
      drive(32'd0, 64'h208, 1'b0, 1'b1, 5'd31, 64'h55);  tick();
      drive(I_ADDZ, 64'h20C, 1'b0, 1'b0, 5'd0, 64'd0);   tick();
      check("xzr busA", busA_EX, 64'd0);

      // Load-use: one stall cycle, bubble, then the dependent issues
      drive(I_LDUR, 64'h300, 1'b0, 1'b0, 5'd0, 64'd0);   tick();
      check("ldur imm", imm_EX, 64'd8);
      check("ldur memread", 64'(memread_EX), 64'd1);
      drive(I_DEP, 64'h304, 1'b0, 1'b0, 5'd0, 64'd0);
      #1 check("lu stall", 64'(stall_IF), 64'd1);
      tick();
      check("lu bubble memread", 64'(memread_EX), 64'd0);
      check("lu bubble regwrite", 64'(regwrite_EX), 64'd0);
      check("lu bubble illegal", 64'(illegal_EX), 64'd0);
      check("lu stall released", 64'(stall_IF), 64'd0);
      tick();
      check("lu issue regwrite", 64'(regwrite_EX), 64'd1);
      check("lu issue rd", 64'(rd_EX), 64'd3);
      check("lu issue busA", busA_EX, 64'd5);

      // Flush of a plain instruction, then flush on top of a hazard
      drive(I_ADD, 64'h400, 1'b1, 1'b0, 5'd0, 64'd0);    tick();
      check("flush regwrite", 64'(regwrite_EX), 64'd0);
      check("flush pc", pc_EX, 64'd0);
      drive(I_LDUR, 64'h404, 1'b0, 1'b0, 5'd0, 64'd0);   tick();
      drive(I_DEP, 64'h408, 1'b1, 1'b0, 5'd0, 64'd0);
      #1 check("flush+hz stall", 64'(stall_IF), 64'd0);
      tick();
      check("flush+hz regwrite", 64'(regwrite_EX), 64'd0);
      check("flush+hz memread", 64'(memread_EX), 64'd0);

      // CBZ negative offset and an unknown encoding
      drive(32'd0, 64'h500, 1'b0, 1'b1, 5'd5, 64'h77);   tick();
      drive(I_CBZ, 64'h504, 1'b0, 1'b0, 5'd0, 64'd0);    tick();
      check("cbz imm", imm_EX, 64'hFFFFFFFFFFFFFFF0);
      check("cbz flag", 64'(cbz_EX), 64'd1);
      check("cbz rm", 64'(rm_EX), 64'd5);
      check("cbz busB", busB_EX, 64'h77);
      check("cbz aluctl", 64'(aluctl_EX), 64'b0111);
      drive(I_ILL, 64'h508, 1'b0, 1'b0, 5'd0, 64'd0);    tick();
      check("ill flag", 64'(illegal_EX), 64'd1);
      check("ill others", 64'({aluctl_EX, alusrc_EX, memread_EX, memwrite_EX, memtoreg_EX,
                               regwrite_EX, cbz_EX, uncond_EX}), 64'd0);

      // Reset while a stall is pending
      drive(I_LDUR, 64'h600, 1'b0, 1'b0, 5'd0, 64'd0);   tick();
      drive(I_DEP, 64'h604, 1'b0, 1'b0, 5'd0, 64'd0);
      #1 check("pre-rst stall", 64'(stall_IF), 64'd1);
      resetl = 1'b0;
      #1;
      check("mid-rst stall", 64'(stall_IF), 64'd0);
      check("mid-rst memread", 64'(memread_EX), 64'd0);
      check("mid-rst pc", pc_EX, 64'd0);
      tick();
      resetl = 1'b1;

      // Random traffic; IF holds its instruction while stalled
      curIns = genInstr();
      curPc  = {$urandom, $urandom};
      for (int n = 0; n < 1500; n++) begin
         if (!lastStall) begin
            curIns = genInstr();
            curPc  = {$urandom, $urandom};
         end
         drive(curIns, curPc, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
               ridx(), {$urandom, $urandom});
         tick();
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
